// File: rtl/fifo_rd_burst_ctrl_pkg.sv
// Shared defaults and width helpers for the FIFO read-side burst controller.
package fifo_rd_burst_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 12;
  localparam int BURST_LEN_DEF  = 256;

  // Width of a counter that must reach burst_len-1.
  function automatic int beat_w(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction
endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO that absorbs the FIFO read latency; head data is a flop.
module skid_buf2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] data
);
  logic [1:0][W-1:0] mem, mem_nxt;
  logic              wr_ptr, rd_ptr, rd_nxt;

  always_comb begin
    mem_nxt = mem;
    if (push) mem_nxt[wr_ptr] = push_data;
    rd_nxt = rd_ptr ^ pop;
  end

  // Head is re-registered from the post-update view so data never lags a push into an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      data   <= '0;
    end else begin
      mem    <= mem_nxt;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_nxt;
      occ    <= occ + {1'b0, push} - {1'b0, pop};
      data   <= mem_nxt[rd_nxt];
    end
  end
endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side FIFO consumer: issues rd_en, buffers latency-1 data, emits a valid/ready stream with burst tags.
module fifo_rd_burst_ctrl
  import fifo_rd_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int WCNT_W     = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  en,
  input  logic                  burst_clr,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [WCNT_W-1:0]     word_cnt
);
  localparam int              BEAT_W    = beat_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic              inflight;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        lvl;
  logic [BEAT_W-1:0] beat_cnt;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (beat_cnt == BEAT_LAST);

  // Committed words after this edge; issuing only below 2 keeps the buffer from overflowing.
  assign lvl        = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = rd_rst_n & en & ~fifo_empty & (lvl < 3'd2);

  skid_buf2 #(.W(DATA_WIDTH)) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .data      (m_data)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (burst_clr)   beat_cnt <= '0;
      else if (pop)    beat_cnt <= m_last ? '0 : beat_cnt + BEAT_W'(1);
      if (pop)         word_cnt <= word_cnt + WCNT_W'(1);
    end
  end
endmodule
